// File: rtl/downcounter_arbiter.sv
// Round-robin arbiter sharing one down-counter between two requesters.
// The owner gets its value loaded, counts to zero, then a done pulse.
module downcounter_arbiter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0,
   input  logic [WIDTH-1:0] val0,
   input  logic             req1,
   input  logic [WIDTH-1:0] val1,
   input  logic             pause,
   output logic             gnt0,
   output logic             gnt1,
   output logic             done0,
   output logic             done1,
   output logic             busy,
   output logic [WIDTH-1:0] q
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             gnt0_q, gnt0_d;
   logic             gnt1_q, gnt1_d;
   logic             done0_q, done0_d;
   logic             done1_q, done1_d;
   logic             last_q, last_d;
   logic             win1;

   // last_q=1 means requester 1 was served last, so 0 wins a tie
   assign win1 = req1 & (~req0 | ~last_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gnt0_q  <= gnt0_d;
         gnt1_q  <= gnt1_d;
         done0_q <= done0_d;
         done1_q <= done1_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gnt0_d  = gnt0_q;
      gnt1_d  = gnt1_q;
      done0_d = 1'b0;
      done1_d = 1'b0;
      last_d  = last_q;
      unique case (state_q)
         IDLE: begin
            if (req0 | req1) begin
               gnt0_d  = ~win1;
               gnt1_d  = win1;
               cnt_d   = win1 ? val1 : val0;
               state_d = COUNT;
            end
         end
         COUNT: begin
            if (!pause) begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - WIDTH'(1);
               end else begin
                  state_d = DONE;
                  gnt0_d  = 1'b0;
                  gnt1_d  = 1'b0;
                  done0_d = gnt0_q;
                  done1_d = gnt1_q;
                  last_d  = gnt1_q;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            gnt0_d  = 1'b0;
            gnt1_d  = 1'b0;
         end
      endcase
   end

   assign gnt0  = gnt0_q;
   assign gnt1  = gnt1_q;
   assign done0 = done0_q;
   assign done1 = done1_q;
   assign busy  = (state_q != IDLE);
   assign q     = cnt_q;

endmodule

// File: tb/tb_downcounter_arbiter.sv
// Bench for downcounter_arbiter: transaction-level model compared
// every cycle, plus directed literal checks and random traffic.
module tb_downcounter_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic       req0, req1, pause;
   logic [3:0] val0, val1;
   logic       gnt0, gnt1, done0, done1, busy;
   logic [3:0] q;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   downcounter_arbiter #(.WIDTH(4)) dut (
      .clk  (clk),
      .reset(reset),
      .req0 (req0),
      .val0 (val0),
      .req1 (req1),
      .val1 (val1),
      .pause(pause),
      .gnt0 (gnt0),
      .gnt1 (gnt1),
      .done0(done0),
      .done1(done1),
      .busy (busy),
      .q    (q)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Model: who owns the counter, what is left, who is finishing
   int m_owner, m_done, m_last, m_q;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_owner = -1;
         m_done  = -1;
         m_last  = 1;
         m_q     = 0;
      end else if (m_done >= 0) begin
         m_done = -1;
      end else if (m_owner >= 0) begin
         if (!pause) begin
            if (m_q > 0) m_q = m_q - 1;
            else begin
               m_done  = m_owner;
               m_last  = m_owner;
               m_owner = -1;
            end
         end
      end else if (req0 || req1) begin
         if (req0 && req1) m_owner = 1 - m_last;
         else m_owner = req0 ? 0 : 1;
         m_q = (m_owner == 0) ? int'(val0) : int'(val1);
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("q", q, m_q);
         chk("gnt0", gnt0, m_owner == 0);
         chk("gnt1", gnt1, m_owner == 1);
         chk("done0", done0, m_done == 0);
         chk("done1", done1, m_done == 1);
         chk("busy", busy, (m_owner >= 0) || (m_done >= 0));
         chk("excl", (gnt0 & gnt1) | (done0 & done1)
                     | ((gnt0 | gnt1) & (done0 | done1)), 0);
      end
   end

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain;
      int n;
      n = 0;
      while (busy && n < 30) begin
         tick();
         n++;
      end
      chk("drain_timeout", busy, 0);
   endtask

   initial begin
      int eq[5], eg[5], ed[5], eb[5];
      int g, d, n;
      int starts[$];
      int lens[$];
      int run;
      logic pg0, pg1;

      reset = 1'b1;
      req0  = 1'b0;
      req1  = 1'b0;
      pause = 1'b0;
      val0  = '0;
      val1  = '0;
      tick();
      cmp_en = 1'b1;
      chk("rst_q", q, 0);
      chk("rst_gnt0", gnt0, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done0", done0, 0);
      reset = 1'b0;

      // single request, V=3
      req0 = 1'b1;
      val0 = 4'd3;
      tick();
      chk("t1_q0", q, 3);
      chk("t1_g0", gnt0, 1);
      req0 = 1'b0;
      eq = '{2, 1, 0, 0, 0};
      eg = '{1, 1, 1, 0, 0};
      ed = '{0, 0, 0, 1, 0};
      eb = '{1, 1, 1, 1, 0};
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t1_q", q, eq[i]);
         chk("t1_gnt0", gnt0, eg[i]);
         chk("t1_done0", done0, ed[i]);
         chk("t1_busy", busy, eb[i]);
      end

      // zero load
      req0 = 1'b1;
      val0 = 4'd0;
      tick();
      chk("z_g0", gnt0, 1);
      chk("z_q", q, 0);
      req0 = 1'b0;
      tick();
      chk("z_g0b", gnt0, 0);
      chk("z_d0", done0, 1);
      chk("z_qb", q, 0);
      tick();
      chk("z_d0c", done0, 0);
      chk("z_qc", q, 0);

      // pause while q=2, V=4
      req1 = 1'b1;
      val1 = 4'd4;
      tick();
      g = gnt1;
      req1 = 1'b0;
      repeat (2) begin
         tick();
         g += gnt1;
      end
      chk("p_q2", q, 2);
      pause = 1'b1;
      repeat (3) begin
         tick();
         g += gnt1;
         chk("p_hold", q, 2);
      end
      pause = 1'b0;
      d = 0;
      repeat (6) begin
         tick();
         g += gnt1;
         d += done1;
      end
      chk("p_gnt1_len", g, 8);
      chk("p_done1_cnt", d, 1);

      // reset in the middle of a count
      req1 = 1'b1;
      val1 = 4'd6;
      tick();
      req1 = 1'b0;
      n = 0;
      while (q != 4'd3 && n < 10) begin
         tick();
         n++;
      end
      chk("mr_reach3", q, 3);
      #2 reset = 1'b1;
      #1;
      chk("mr_q", q, 0);
      chk("mr_gnt1", gnt1, 0);
      chk("mr_busy", busy, 0);
      chk("mr_done1", done1, 0);
      @(negedge clk);
      reset = 1'b0;

      // contention, both held
      req0 = 1'b1;
      req1 = 1'b1;
      val0 = 4'd2;
      val1 = 4'd5;
      pg0 = 1'b0;
      pg1 = 1'b0;
      run = 0;
      repeat (26) begin
         tick();
         if (gnt0 && !pg0) starts.push_back(0);
         if (gnt1 && !pg1) starts.push_back(1);
         if (gnt0 || gnt1) run++;
         else if (pg0 || pg1) begin
            lens.push_back(run);
            run = 0;
         end
         pg0 = gnt0;
         pg1 = gnt1;
      end
      chk("c_nstarts", starts.size() >= 3, 1);
      chk("c_nlens", lens.size() >= 2, 1);
      if (starts.size() >= 3) begin
         chk("c_first", starts[0], 0);
         chk("c_second", starts[1], 1);
         chk("c_third", starts[2], 0);
      end
      if (lens.size() >= 2) begin
         chk("c_len0", lens[0], 3);
         chk("c_len1", lens[1], 6);
      end
      req0 = 1'b0;
      req1 = 1'b0;
      drain();

      // late request arrives during count
      req0 = 1'b1;
      val0 = 4'd2;
      tick();
      chk("l_q2", q, 2);
      req0 = 1'b0;
      tick();
      chk("l_q1", q, 1);
      req1 = 1'b1;
      val1 = 4'd7;
      tick();
      chk("l_g1_a", gnt1, 0);
      tick();
      chk("l_d0", done0, 1);
      chk("l_g1_b", gnt1, 0);
      tick();
      chk("l_idle", busy, 0);
      chk("l_g1_c", gnt1, 0);
      val1 = 4'd9;
      tick();
      chk("l_g1", gnt1, 1);
      chk("l_q9", q, 9);
      req1 = 1'b0;
      drain();

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         #2;
         reset = ($urandom_range(0, 199) == 0);
         req0  = ($urandom_range(0, 2) != 0);
         req1  = ($urandom_range(0, 2) != 0);
         pause = ($urandom_range(0, 3) == 0);
         val0  = 4'($urandom_range(0, 15));
         val1  = 4'($urandom_range(0, 15));
      end
      @(negedge clk);
      #2 reset = 1'b0;
      repeat (3) tick();

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/downcounter_arbiter.md
# downcounter_arbiter

Round-robin arbiter and sequencer that shares one 4-bit synchronous down-counter between two requesters. A granted requester's load value is loaded into the shared counter, which counts down to zero. The owner then receives a one-cycle done pulse and the counter is released. It sits between the requesting blocks and the shared down-counter datapath, and owns the counter register internally.

## Interface
Parameters:
- WIDTH, 4, counter and load-value width

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req0  input  1  requester 0 request, level-sensitive
- val0  input  WIDTH  requester 0 load value, sampled only at the cycle requester 0 is granted
- req1  input  1  requester 1 request, level-sensitive
- val1  input  WIDTH  requester 1 load value, sampled only at the cycle requester 1 is granted
- pause  input  1  holds the count while in COUNT; ignored in other states
- gnt0  output  1  requester 0 owns the counter
- gnt1  output  1  requester 1 owns the counter
- done0  output  1  one-cycle pulse: requester 0's count has completed
- done1  output  1  one-cycle pulse: requester 1's count has completed
- busy  output  1  high whenever the state is not IDLE
- q  output  WIDTH  current counter value

## Operation
- Clocking and reset: one clock, clk. Reset is asynchronous and active-high.
- Reset values:
  - state = IDLE
  - q = 0
  - gnt0 = gnt1 = 0
  - done0 = done1 = 0
  - busy = 0
  - last-served pointer = 1, so requester 0 wins the first contention.
- The FSM has three states: IDLE, COUNT and DONE. All outputs are registered except busy, which is decoded from the state register.
- IDLE:
  - No request: stay in IDLE. q holds its value.
  - Exactly one request: grant that requester.
  - Both requests: grant the requester that was not last served.
  - On a grant: q ← val of the winner, the winner's gnt goes to 1, next state = COUNT.
- COUNT:
  - pause=1: q and state hold.
  - pause=0 and q≠0: q ← q−1.
  - pause=0 and q=0: next state = DONE. Clear gnt, set the owner's done, and update last-served to the owner.
- DONE:
  - The done pulse is active for this one cycle, then cleared.
  - q stays 0.
  - Next state = IDLE unconditionally. Requests are not examined in DONE.
- Requests:
  - A request is consumed by its grant.
  - A req still high when the FSM returns to IDLE is treated as a new request.
- Exclusivity: gnt0 and gnt1 are never high together. done0 and done1 are never high together.
- Width rule: q never wraps below 0. A decrement is never applied when q=0.

## Timing
- Let E0 be the edge at which IDLE samples a request and the load value is V.
- E0: q=V, gnt=1, busy=1.
- E1..EV: q counts V−1 down to 0, one step per unpaused edge.
- E(V+1): gnt=0, done=1, state = DONE.
- E(V+2): done=0, state = IDLE, busy=0.
- Grant duration is V+1 cycles with no pause. Each paused cycle in COUNT extends it by one cycle.
- V=0: gnt is high for 1 cycle and done follows on the next edge.
- Back-to-back requests: the next grant is issued no earlier than E(V+3). This gives one mandatory IDLE sampling cycle after DONE.
- A request that arrives during COUNT or DONE waits. It is served at the next IDLE, subject to round-robin.
- Reset mid-operation (any state): all outputs and the pointer return to their reset values immediately. No done pulse is emitted for the aborted count.

## Test plan
- After reset: req0=1, val0=3, req1=0.
  - q sequence 3,2,1,0.
  - gnt0 high for 4 cycles.
  - done0 high for exactly 1 cycle, then busy=0.
- Contention: req0=req1=1 held continuously, val0=2, val1=5.
  - Grant order is gnt0, gnt1, gnt0, …
  - done0 follows 3 cycles of gnt0.
  - done1 follows 6 cycles of gnt1.
  - gnt is never asserted in DONE cycles.
- Pause: val1=4, pause=1 for 3 cycles while q=2.
  - q holds at 2 during the pause.
  - gnt1 duration is 8 cycles.
  - done1 pulses once.
- Zero load: val0=0.
  - gnt0 high for 1 cycle.
  - done0 on the next cycle.
  - q stays 0, with no wrap to 15.
- Reset mid-count: assert reset while q=3 under gnt1.
  - q=0, gnt1=0, busy=0 immediately, with no done1 pulse.
  - Afterwards, with both requests high, requester 0 wins.
- Late request: req1 rises while q=1 under gnt0.
  - gnt1 is asserted at the first IDLE edge after done0, not before.
  - val1 is sampled at that edge.
